// File: rtl/arb_pkg.sv
// Shared types for the round-robin arbiter: FSM state enum and its idle encoding.
package arb_pkg;

    localparam logic ARB_IDLE_ENC = 1'b0;

    typedef enum logic {
        IDLE  = ARB_IDLE_ENC,
        GRANT = ~ARB_IDLE_ENC
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_pick
    import arb_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 2
) (
    input  logic [2**ADDRESS_WIDTH-1:0] req,
    input  logic [ADDRESS_WIDTH-1:0]    ptr,
    output logic                        found,
    output logic [ADDRESS_WIDTH-1:0]    idx,
    output logic [2**ADDRESS_WIDTH-1:0] onehot
);

    localparam int N = 2**ADDRESS_WIDTH;

    logic [ADDRESS_WIDTH-1:0] cand;

    always_comb begin
        found  = 1'b0;
        idx    = '0;
        onehot = '0;
        cand   = '0;
        // ptr + i wraps naturally at ADDRESS_WIDTH bits
        for (int i = 0; i < N; i++) begin
            cand = ptr + ADDRESS_WIDTH'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        if (found) begin
            onehot = {{(N-1){1'b0}}, 1'b1} << idx;
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter driving a mux select with valid/ready hand-off.
// Optional burst lock input enabled by defining RR_ARBITER_LOCK_EN.
module rr_arbiter
    import arb_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [2**ADDRESS_WIDTH-1:0] req,
    input  logic                        out_ready,
`ifdef RR_ARBITER_LOCK_EN
    input  logic                        lock,
`endif
    output logic [ADDRESS_WIDTH-1:0]    address,
    output logic                        out_valid,
    output logic [2**ADDRESS_WIDTH-1:0] grant
);

    localparam int N = 2**ADDRESS_WIDTH;

    arb_state_t               state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDRESS_WIDTH-1:0] address_q, address_d;
    logic [N-1:0]             grant_q, grant_d;

    logic                     xfer;
    logic                     lock_hold;
    logic [ADDRESS_WIDTH-1:0] pick_ptr;
    logic                     pick_found;
    logic [ADDRESS_WIDTH-1:0] pick_idx;
    logic [N-1:0]             pick_oh;

    assign xfer = (state_q == GRANT) && out_ready;

`ifdef RR_ARBITER_LOCK_EN
    assign lock_hold = lock && req[address_q];
`else
    assign lock_hold = 1'b0;
`endif

    // One picker serves both the idle pick and the post-transfer pick
    assign pick_ptr = xfer ? address_q + ADDRESS_WIDTH'(1) : ptr_q;

    rr_pick #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH)
    ) u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx),
        .onehot(pick_oh)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        address_d = address_q;
        grant_d   = grant_q;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    address_d = pick_idx;
                    grant_d   = pick_oh;
                    state_d   = GRANT;
                end
            end
            GRANT: begin
                if (xfer) begin
                    if (!lock_hold) begin
                        ptr_d = pick_ptr;
                        if (pick_found) begin
                            address_d = pick_idx;
                            grant_d   = pick_oh;
                        end else begin
                            grant_d = '0;
                            state_d = IDLE;
                        end
                    end
                end else if (!req[address_q]) begin
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            address_q <= '0;
            grant_q   <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            address_q <= address_d;
            grant_q   <= grant_d;
        end
    end

    assign address   = address_q;
    assign grant     = grant_q;
    assign out_valid = (state_q == GRANT);

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed self-checking bench for rr_arbiter (N=4).
module tb_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       out_ready;
    logic       lock;
    logic [1:0] address;
    logic       out_valid;
    logic [3:0] grant;

    int checks;
    int failures;

    rr_arbiter #(
        .ADDRESS_WIDTH(2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .out_ready(out_ready),
`ifdef RR_ARBITER_LOCK_EN
        .lock     (lock),
`endif
        .address  (address),
        .out_valid(out_valid),
        .grant    (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req       = 4'b0000;
        out_ready = 1'b0;
        lock      = 1'b0;
        tick();
        tick();
        checks++;
        if ({out_valid, grant, address} !== 7'b0_0000_00) begin
            failures++;
            $display("FAIL reset_hold got v=%b g=%b a=%0d exp v=0 g=0000 a=0",
                     out_valid, grant, address);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({out_valid, grant, address} !== 7'b0_0000_00) begin
                failures++;
                $display("FAIL idle_no_req[%0d] got v=%b g=%b a=%0d exp v=0 g=0000 a=0",
                         i, out_valid, grant, address);
            end
        end
    endtask

    task automatic test_rotate();
        logic [1:0] exp_a [4];
        logic [3:0] exp_g [4];
        exp_a = '{2'd1, 2'd3, 2'd1, 2'd3};
        exp_g = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
        req       = 4'b1010;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({out_valid, grant, address} !== {1'b1, exp_g[i], exp_a[i]}) begin
                failures++;
                $display("FAIL rotate[%0d] got v=%b g=%b a=%0d exp v=1 g=%b a=%0d",
                         i, out_valid, grant, address, exp_g[i], exp_a[i]);
            end
        end
        req = 4'b0000;
        tick();
        checks++;
        if ({out_valid, grant} !== 5'b0_0000) begin
            failures++;
            $display("FAIL rotate_drain got v=%b g=%b exp v=0 g=0000",
                     out_valid, grant);
        end
    endtask

    task automatic test_hold();
        req       = 4'b0001;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({out_valid, grant, address} !== 7'b1_0001_00) begin
                failures++;
                $display("FAIL hold[%0d] got v=%b g=%b a=%0d exp v=1 g=0001 a=0",
                         i, out_valid, grant, address);
            end
            if (i == 2) out_ready = 1'b1;
        end
        req = 4'b0000;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL hold_single_xfer got v=%b exp v=0", out_valid);
        end
        // ptr is now 1, so slot 1 beats slot 0
        req       = 4'b0011;
        out_ready = 1'b0;
        tick();
        checks++;
        if ({out_valid, grant, address} !== 7'b1_0010_01) begin
            failures++;
            $display("FAIL hold_ptr_adv got v=%b g=%b a=%0d exp v=1 g=0010 a=1",
                     out_valid, grant, address);
        end
        req       = 4'b0000;
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_wrap();
        req       = 4'b1001;
        out_ready = 1'b0;
        tick();
        checks++;
        if ({out_valid, grant, address} !== 7'b1_1000_11) begin
            failures++;
            $display("FAIL wrap_pick got v=%b g=%b a=%0d exp v=1 g=1000 a=3",
                     out_valid, grant, address);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if ({out_valid, grant, address} !== 7'b1_0001_00) begin
            failures++;
            $display("FAIL wrap_next got v=%b g=%b a=%0d exp v=1 g=0001 a=0",
                     out_valid, grant, address);
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_withdraw();
        req       = 4'b0100;
        out_ready = 1'b0;
        tick();
        checks++;
        if ({out_valid, grant, address} !== 7'b1_0100_10) begin
            failures++;
            $display("FAIL withdraw_pick got v=%b g=%b a=%0d exp v=1 g=0100 a=2",
                     out_valid, grant, address);
        end
        req = 4'b0000;
        tick();
        checks++;
        if ({out_valid, grant} !== 5'b0_0000) begin
            failures++;
            $display("FAIL withdraw_drop got v=%b g=%b exp v=0 g=0000",
                     out_valid, grant);
        end
        // ptr still 1: slot 2 wins over slot 0
        req = 4'b0101;
        tick();
        checks++;
        if ({out_valid, grant, address} !== 7'b1_0100_10) begin
            failures++;
            $display("FAIL withdraw_rereq got v=%b g=%b a=%0d exp v=1 g=0100 a=2",
                     out_valid, grant, address);
        end
        req       = 4'b0000;
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        // ready high while idle must not move anything
        req       = 4'b0000;
        out_ready = 1'b1;
        tick();
        tick();
        checks++;
        if ({out_valid, grant} !== 5'b0_0000) begin
            failures++;
            $display("FAIL idle_ready got v=%b g=%b exp v=0 g=0000",
                     out_valid, grant);
        end
        req = 4'b0001;
        tick();
        checks++;
        if ({out_valid, grant, address} !== 7'b1_0001_00) begin
            failures++;
            $display("FAIL b2b_first got v=%b g=%b a=%0d exp v=1 g=0001 a=0",
                     out_valid, grant, address);
        end
        tick();
        checks++;
        if ({out_valid, grant, address} !== 7'b1_0001_00) begin
            failures++;
            $display("FAIL b2b_second got v=%b g=%b a=%0d exp v=1 g=0001 a=0",
                     out_valid, grant, address);
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_no_preempt();
        req       = 4'b0100;
        out_ready = 1'b0;
        tick();
        req = 4'b0110;
        tick();
        checks++;
        if ({out_valid, grant, address} !== 7'b1_0100_10) begin
            failures++;
            $display("FAIL no_preempt got v=%b g=%b a=%0d exp v=1 g=0100 a=2",
                     out_valid, grant, address);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if ({out_valid, grant, address} !== 7'b1_0010_01) begin
            failures++;
            $display("FAIL preempt_after got v=%b g=%b a=%0d exp v=1 g=0010 a=1",
                     out_valid, grant, address);
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_reset_mid();
        req       = 4'b1000;
        out_ready = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, grant, address} !== 7'b0_0000_00) begin
            failures++;
            $display("FAIL reset_mid got v=%b g=%b a=%0d exp v=0 g=0000 a=0",
                     out_valid, grant, address);
        end
        req = 4'b0000;
        tick();
        rst_n = 1'b1;
        // ptr back to 0: slot 0 wins over slot 3
        req = 4'b1001;
        tick();
        checks++;
        if ({out_valid, grant, address} !== 7'b1_0001_00) begin
            failures++;
            $display("FAIL reset_mid_ptr got v=%b g=%b a=%0d exp v=1 g=0001 a=0",
                     out_valid, grant, address);
        end
        req       = 4'b0000;
        out_ready = 1'b1;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

`ifdef RR_ARBITER_LOCK_EN
    task automatic test_lock();
        req       = 4'b0011;
        lock      = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({out_valid, grant, address} !== 7'b1_0001_00) begin
                failures++;
                $display("FAIL lock_hold[%0d] got v=%b g=%b a=%0d exp v=1 g=0001 a=0",
                         i, out_valid, grant, address);
            end
        end
        lock = 1'b0;
        tick();
        checks++;
        if ({out_valid, grant, address} !== 7'b1_0010_01) begin
            failures++;
            $display("FAIL lock_release got v=%b g=%b a=%0d exp v=1 g=0010 a=1",
                     out_valid, grant, address);
        end
        req = 4'b0000;
        tick();
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_rotate();
        test_hold();
        test_wrap();
        test_withdraw();
        test_back_to_back();
        test_no_preempt();
        test_reset_mid();
`ifdef RR_ARBITER_LOCK_EN
        test_lock();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
